// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider: one operand pair in, 32 shift/subtract
// cycles, then a one-cycle {quotient, remainder} valid pulse.
module iter_div #(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] dout_q, dout_d;

  logic                      accept;
  logic signed [DATA_W-1:0]  dvd_s;
  logic signed [DATA_W-1:0]  dvs_s;
  logic                      dvd_neg;
  logic                      dvs_neg;
  logic [DATA_W:0]           trial;
  logic [DATA_W:0]           diff;

  // Two's-complement negate; 32'h8000_0000 maps to itself, which is the
  // correct unsigned magnitude, so no saturation is needed.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dout_d  = dout_q;

    dvd_s   = s_axis_dividend_tdata;
    dvs_s   = s_axis_divisor_tdata;
    dvd_neg = (SIGNED != 0) && (dvd_s < 0);
    dvs_neg = (SIGNED != 0) && (dvs_s < 0);
    accept  = s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    // Partial remainder after the left shift, then trial subtract.
    trial = {rem_q, quo_q[DATA_W-1]};
    diff  = trial - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = cond_neg(s_axis_dividend_tdata, dvd_neg);
          dvs_d   = cond_neg(s_axis_divisor_tdata, dvs_neg);
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
        end
      end
      CALC: begin
        if (!diff[DATA_W]) begin
          rem_d = diff[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          dout_d  = {cond_neg(quo_d, qneg_q), cond_neg(rem_d, rneg_q)};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign s_axis_divisor_tready  = (state_q == IDLE) && !rst;
  assign s_axis_dividend_tready = (state_q == IDLE) && !rst;
  assign m_axis_dout_tvalid     = (state_q == DONE);
  assign m_axis_dout_tdata      = dout_q;

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: unsigned and signed instances share stimulus; vectors
// carry hand-computed results for both interpretations.
module tb_iter_div;

  logic        clk;
  logic        rst;
  logic [31:0] dvs_data;
  logic        dvs_vld;
  logic [31:0] dvd_data;
  logic        dvd_vld;

  logic        u_dvs_rdy, u_dvd_rdy, u_vld;
  logic [63:0] u_dout;
  logic        s_dvs_rdy, s_dvd_rdy, s_vld;
  logic [63:0] s_dout;

  int total;
  int bad;

  iter_div #(.SIGNED(0)) u_divu (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tvalid  (dvs_vld),
    .s_axis_divisor_tready  (u_dvs_rdy),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tvalid (dvd_vld),
    .s_axis_dividend_tready (u_dvd_rdy),
    .m_axis_dout_tdata      (u_dout),
    .m_axis_dout_tvalid     (u_vld)
  );

  iter_div #(.SIGNED(1)) u_divs (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tvalid  (dvs_vld),
    .s_axis_divisor_tready  (s_dvs_rdy),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tvalid (dvd_vld),
    .s_axis_dividend_tready (s_dvd_rdy),
    .m_axis_dout_tdata      (s_dout),
    .m_axis_dout_tvalid     (s_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [63:0] exp_u;
    logic [63:0] exp_s;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rdys();
    return {u_dvs_rdy, u_dvd_rdy, s_dvs_rdy, s_dvd_rdy};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          first_u;
    int          first_s;
    int          n_u;
    int          n_s;
    logic        busy_rdy;
    first_u  = 0;
    first_s  = 0;
    n_u      = 0;
    n_s      = 0;
    busy_rdy = 1'b0;
    @(negedge clk);
    dvd_data = v.dvd;
    dvs_data = v.dvs;
    dvd_vld  = 1'b1;
    dvs_vld  = 1'b1;
    check({tag, "_rdy_accept"}, 64'(rdys()), 64'hF);
    @(posedge clk);
    #1;
    dvd_vld  = 1'b0;
    dvs_vld  = 1'b0;
    dvd_data = ~v.dvd;
    dvs_data = v.dvs ^ 32'h5A5A_5A5A;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (u_vld) begin
        n_u++;
        if (first_u == 0) first_u = k;
      end
      if (s_vld) begin
        n_s++;
        if (first_s == 0) first_s = k;
      end
      if (k <= 33 && rdys() != 4'h0) busy_rdy = 1'b1;
      if (k == 33) begin
        check({tag, "_dout_u"}, u_dout, v.exp_u);
        check({tag, "_dout_s"}, s_dout, v.exp_s);
      end
      if (k == 34) check({tag, "_rdy_after"}, 64'(rdys()), 64'hF);
      if (k == 36) begin
        check({tag, "_hold_u"}, u_dout, v.exp_u);
        check({tag, "_hold_s"}, s_dout, v.exp_s);
      end
      // Valids wiggle mid-calculation with scrambled data; must be ignored.
      if (k == 10) begin dvd_vld = 1'b1; dvs_vld = 1'b1; end
      if (k == 20) begin dvd_vld = 1'b0; dvs_vld = 1'b0; end
    end
    check({tag, "_lat_u"}, 64'(first_u), 64'd33);
    check({tag, "_lat_s"}, 64'(first_s), 64'd33);
    check({tag, "_pulses"}, 64'(n_u + n_s), 64'd2);
    check({tag, "_busy_rdy"}, 64'(busy_rdy), 64'd0);
  endtask

  initial begin
    int rdy_bad;
    int vld_bad;
    int pulses;
    logic exp_r;
    logic exp_v;

    total = 0;
    bad   = 0;
    vecs[0]  = '{32'h0000_0007, 32'h0000_0002, 64'h00000003_00000001, 64'h00000003_00000001};
    vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0002, 64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF};
    vecs[2]  = '{32'h0000_0007, 32'hFFFF_FFFE, 64'h00000000_00000007, 64'hFFFFFFFD_00000001};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 64'h80000000_00000000};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0000, 64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005};
    vecs[6]  = '{32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFFFFFF_FFFFFFFB, 64'h00000001_FFFFFFFB};
    vecs[7]  = '{32'h0000_0064, 32'h0000_0007, 64'h0000000E_00000002, 64'h0000000E_00000002};
    vecs[8]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'h00000000_FFFFFF9C, 64'h0000000E_FFFFFFFE};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0005, 64'h00000000_00000000, 64'h00000000_00000000};
    vecs[10] = '{32'h1234_5678, 32'h0000_1000, 64'h00012345_00000678, 64'h00012345_00000678};

    rst      = 1'b1;
    dvs_data = '0;
    dvd_data = '0;
    dvs_vld  = 1'b0;
    dvd_vld  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(rdys()), 64'h0);
    check("rst_vld", 64'({u_vld, s_vld}), 64'h0);
    check("rst_dout_u", u_dout, 64'h0);
    check("rst_dout_s", s_dout, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(rdys()), 64'hF);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Only the divisor is offered: nothing may be accepted.
    rdy_bad = 0;
    pulses  = 0;
    @(negedge clk);
    dvs_data = 32'd3;
    dvd_data = 32'd9;
    dvs_vld  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (rdys() != 4'hF) rdy_bad++;
    end
    dvs_vld = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_vld || s_vld) pulses++;
    end
    check("one_side_rdy", 64'(rdy_bad), 64'd0);
    check("one_side_pulses", 64'(pulses), 64'd0);

    // Both valids held continuously: accepts every 34 cycles.
    rdy_bad = 0;
    vld_bad = 0;
    @(negedge clk);
    dvd_data = 32'd100;
    dvs_data = 32'd7;
    dvd_vld  = 1'b1;
    dvs_vld  = 1'b1;
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) @(negedge clk);
      exp_r = (k % 34 == 0);
      exp_v = (k % 34 == 33);
      if (rdys() != {4{exp_r}}) rdy_bad++;
      if ({u_vld, s_vld} != {2{exp_v}}) vld_bad++;
      if (k == 67) begin
        check("b2b_dout_u", u_dout, 64'h0000000E_00000002);
        check("b2b_dout_s", s_dout, 64'h0000000E_00000002);
      end
    end
    dvd_vld = 1'b0;
    dvs_vld = 1'b0;
    check("b2b_rdy_pattern", 64'(rdy_bad), 64'd0);
    check("b2b_vld_pattern", 64'(vld_bad), 64'd0);
    repeat (2) @(negedge clk);

    // Reset in cycle 15 of an operation drops it.
    pulses = 0;
    @(negedge clk);
    dvd_data = 32'd1000;
    dvs_data = 32'd3;
    dvd_vld  = 1'b1;
    dvs_vld  = 1'b1;
    @(posedge clk);
    #1;
    dvd_vld = 1'b0;
    dvs_vld = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rdy_in_rst", 64'(rdys()), 64'h0);
    @(negedge clk);
    check("midrst_dout_u", u_dout, 64'h0);
    check("midrst_dout_s", s_dout, 64'h0);
    check("midrst_vld", 64'({u_vld, s_vld}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy_after", 64'(rdys()), 64'hF);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_vld || s_vld) pulses++;
    end
    check("midrst_pulses", 64'(pulses), 64'd0);
    run_vec(vecs[7], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
